can_tx_scheduler: RTL and testbench

- Multi-mailbox transmit scheduler in front of the single CAN controller.
- Host software loads up to NUM_MBOX frames (ID + payload) into mailboxes.
- The scheduler selects the highest-priority pending mailbox (lowest ID), presents it on the controller's In_packet/Tx_ID inputs, and holds it across retransmissions.
- It reports per-mailbox completion or failure back to the host.

---
 rtl/can_tx_scheduler_if.sv | 62 ++++++
 rtl/can_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler_if
//
// Purpose:
//   Bundles the host mailbox-load port, the per-mailbox cancel/status vectors
//   and the CAN controller frame hand-off signals of can_tx_scheduler into one
//   interface. Clock and reset are kept as plain ports on the scheduler.
//
// Signal summary:
//   wr_en / wr_sel / wr_id / wr_data : host mailbox load request
//   wr_ack / wr_err                  : load accepted / rejected (registered)
//   abort                            : per-mailbox cancel request (level)
//   data_in_req / Retransmit / tx_ack: controller fetch, error and delivery
//   In_packet / Tx_ID                : frame presented to the controller
//   pending / tx_done / tx_fail      : per-mailbox status to the host
//   busy                             : a frame is committed to the controller
//   retry_cnt / retry_hit            : debug view of the retransmission count
//
// Modports:
//   master : host + controller side (drives requests, observes status)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface can_tx_scheduler_if #(
    parameter int NUM_MBOX = 4,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 11
) ();
    localparam int SEL_W = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1;

    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [ID_W-1:0]     wr_id;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_ack;
    logic                wr_err;
    logic [NUM_MBOX-1:0] abort;
    logic                data_in_req;
    logic                Retransmit;
    logic                tx_ack;
    logic [DATA_W-1:0]   In_packet;
    logic [ID_W-1:0]     Tx_ID;
    logic [NUM_MBOX-1:0] pending;
    logic [NUM_MBOX-1:0] tx_done;
    logic [NUM_MBOX-1:0] tx_fail;
    logic                busy;
    logic [7:0]          retry_cnt;
    logic                retry_hit;

    modport master (
        output wr_en, wr_sel, wr_id, wr_data, abort,
        output data_in_req, Retransmit, tx_ack,
        input  wr_ack, wr_err, In_packet, Tx_ID,
        input  pending, tx_done, tx_fail, busy, retry_cnt, retry_hit
    );

    modport slave (
        input  wr_en, wr_sel, wr_id, wr_data, abort,
        input  data_in_req, Retransmit, tx_ack,
        output wr_ack, wr_err, In_packet, Tx_ID,
        output pending, tx_done, tx_fail, busy, retry_cnt, retry_hit
    );
endinterface

// File: rtl/can_tx_scheduler.sv
// -----------------------------------------------------------------------------
// can_tx_scheduler
//
// Purpose:
//   Multi-mailbox transmit scheduler placed in front of a single CAN
//   controller. The host loads frames (ID + non-zero payload) into NUM_MBOX
//   mailboxes; the scheduler presents the highest-priority pending frame
//   (lowest ID, lower index on ties) on In_packet/Tx_ID, holds it across
//   retransmissions once the controller has fetched it, and reports
//   per-mailbox completion (tx_done) or failure (tx_fail).
//
// Ports:
//   clock : system clock, all logic on posedge
//   reset : asynchronous, active-high; clears all state
//   bus   : can_tx_scheduler_if.slave (host load port, abort vector,
//           controller hand-off, status and debug outputs)
//
// Configuration macro:
//   RETRY_LIMIT_EN - when defined, a committed frame is failed (tx_fail) once
//                    the retransmission counter reaches RETRY_LIMIT. When
//                    undefined the counter is debug-only and a committed frame
//                    stays in flight until tx_ack or reset.
// -----------------------------------------------------------------------------
module can_tx_scheduler #(
    parameter int NUM_MBOX    = 4,
    parameter int DATA_W      = 64,
    parameter int ID_W        = 11,
    parameter int RETRY_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    can_tx_scheduler_if.slave   bus
);
    localparam int         SEL_W         = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1;
    localparam logic [7:0] RETRY_LIMIT_W = 8'(RETRY_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_IN_FLIGHT = 2'd2
    } state_t;

    // One-hot mask of a mailbox index.
    function automatic logic [NUM_MBOX-1:0] mbox_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_MBOX-1:0] base;
        base = {{(NUM_MBOX-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

    // Registered state
    state_t              state_r;
    logic [SEL_W-1:0]    sel_r;
    logic [ID_W-1:0]     id_mem_r   [NUM_MBOX];
    logic [DATA_W-1:0]   data_mem_r [NUM_MBOX];
    logic [NUM_MBOX-1:0] pending_r;
    logic [NUM_MBOX-1:0] tx_done_r;
    logic [NUM_MBOX-1:0] tx_fail_r;
    logic                wr_ack_r;
    logic                wr_err_r;
    logic                busy_r;
    logic [DATA_W-1:0]   in_packet_r;
    logic [ID_W-1:0]     tx_id_r;
    logic [7:0]          retry_cnt_r;
    logic                retry_hit_r;
    logic                retx_d_r;

    // Combinational decode
    logic                in_flight_s;
    logic [NUM_MBOX-1:0] flight_mask_s;
    logic [NUM_MBOX-1:0] abort_clr_s;
    logic [NUM_MBOX-1:0] cand_s;
    logic                cand_any_s;
    logic [SEL_W-1:0]    best_idx_s;
    logic [ID_W-1:0]     best_id_s;
    logic                arm_drop_s;
    logic                commit_s;
    logic                done_s;
    logic                limit_fail_s;
    logic                retx_rise_s;
    logic                wr_in_range_s;
    logic                wr_target_busy_s;
    logic                load_ok_s;
    logic [NUM_MBOX-1:0] load_set_s;
    logic [NUM_MBOX-1:0] fsm_clr_s;
    logic [NUM_MBOX-1:0] pending_nxt_s;
    logic [7:0]          retry_nxt_s;

    // Event decode: aborts, delivery, retry-limit failure and load admission.
    always_comb begin
        in_flight_s   = (state_r == ST_IN_FLIGHT);
        flight_mask_s = in_flight_s ? mbox_onehot(sel_r) : '0;
        // The committed mailbox cannot be cancelled; every other pending one can.
        abort_clr_s   = bus.abort & pending_r & ~flight_mask_s;
        cand_s        = pending_r & ~bus.abort;
        done_s        = in_flight_s & bus.tx_ack;
        retx_rise_s   = bus.Retransmit & ~retx_d_r;
`ifdef RETRY_LIMIT_EN
        limit_fail_s  = in_flight_s & ~bus.tx_ack & retry_hit_r;
`else
        limit_fail_s  = 1'b0;
`endif
        wr_in_range_s = (int'(bus.wr_sel) < NUM_MBOX);
        if (wr_in_range_s) begin
            // An abort in the same cycle frees the mailbox before the load is judged.
            wr_target_busy_s = pending_r[bus.wr_sel] & ~abort_clr_s[bus.wr_sel];
        end else begin
            wr_target_busy_s = 1'b1;
        end
        load_ok_s     = bus.wr_en & wr_in_range_s & (bus.wr_data != '0) & ~wr_target_busy_s;
        load_set_s    = load_ok_s ? mbox_onehot(bus.wr_sel) : '0;
        fsm_clr_s     = (done_s | limit_fail_s) ? mbox_onehot(sel_r) : '0;
        pending_nxt_s = (pending_r & ~abort_clr_s & ~fsm_clr_s) | load_set_s;
    end

    // Priority selection: lowest ID among non-aborted pending mailboxes, lowest index on ties.
    always_comb begin
        cand_any_s = 1'b0;
        best_idx_s = '0;
        best_id_s  = '0;
        for (int k = 0; k < NUM_MBOX; k++) begin
            if (cand_s[k] && (!cand_any_s || (id_mem_r[k] < best_id_s))) begin
                cand_any_s = 1'b1;
                best_idx_s = SEL_W'(k);
                best_id_s  = id_mem_r[k];
            end else begin
                best_idx_s = best_idx_s;
            end
        end
    end

    // ARMED exit conditions and next retransmission count.
    always_comb begin
        arm_drop_s  = ~cand_any_s | bus.abort[sel_r];
        commit_s    = (state_r == ST_ARMED) & ~arm_drop_s & bus.data_in_req;
        retry_nxt_s = retry_cnt_r;
        if (commit_s) begin
            retry_nxt_s = 8'd0;
        end else if (in_flight_s && retx_rise_s && (retry_cnt_r != 8'hFF)) begin
            retry_nxt_s = retry_cnt_r + 8'd1;
        end else begin
            retry_nxt_s = retry_cnt_r;
        end
    end

    // Mailbox storage, pending flags and host/status pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_MBOX; k++) begin
                id_mem_r[k]   <= '0;
                data_mem_r[k] <= '0;
            end
            pending_r <= '0;
            tx_done_r <= '0;
            tx_fail_r <= '0;
            wr_ack_r  <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            if (load_ok_s) begin
                id_mem_r[bus.wr_sel]   <= bus.wr_id;
                data_mem_r[bus.wr_sel] <= bus.wr_data;
            end
            pending_r <= pending_nxt_s;
            tx_done_r <= done_s ? mbox_onehot(sel_r) : '0;
            tx_fail_r <= abort_clr_s | (limit_fail_s ? mbox_onehot(sel_r) : '0);
            wr_ack_r  <= load_ok_s;
            wr_err_r  <= bus.wr_en & ~load_ok_s;
        end
    end

    // Retransmission counter and Retransmit edge detector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_cnt_r <= 8'd0;
            retry_hit_r <= 1'b0;
            retx_d_r    <= 1'b0;
        end else begin
            retry_cnt_r <= retry_nxt_s;
            retry_hit_r <= (retry_nxt_s >= RETRY_LIMIT_W);
            retx_d_r    <= bus.Retransmit;
        end
    end

    // Scheduler FSM with registered frame outputs and busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sel_r       <= '0;
            in_packet_r <= '0;
            tx_id_r     <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (cand_any_s) begin
                        sel_r       <= best_idx_s;
                        in_packet_r <= data_mem_r[best_idx_s];
                        tx_id_r     <= best_id_s;
                        state_r     <= ST_ARMED;
                    end else begin
                        in_packet_r <= '0;
                        tx_id_r     <= '0;
                    end
                end
                ST_ARMED: begin
                    if (arm_drop_s) begin
                        in_packet_r <= '0;
                        tx_id_r     <= '0;
                        state_r     <= ST_IDLE;
                    end else if (bus.data_in_req) begin
                        // The controller captured what is presented now; keep it.
                        busy_r  <= 1'b1;
                        state_r <= ST_IN_FLIGHT;
                    end else begin
                        // Re-select every cycle so a newer, higher-priority frame preempts.
                        sel_r       <= best_idx_s;
                        in_packet_r <= data_mem_r[best_idx_s];
                        tx_id_r     <= best_id_s;
                    end
                end
                ST_IN_FLIGHT: begin
                    // tx_ack wins over a simultaneous data_in_req; refetches otherwise hold.
                    if (done_s || limit_fail_s) begin
                        in_packet_r <= '0;
                        tx_id_r     <= '0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    in_packet_r <= '0;
                    tx_id_r     <= '0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_ack    = wr_ack_r;
    assign bus.wr_err    = wr_err_r;
    assign bus.In_packet = in_packet_r;
    assign bus.Tx_ID     = tx_id_r;
    assign bus.pending   = pending_r;
    assign bus.tx_done   = tx_done_r;
    assign bus.tx_fail   = tx_fail_r;
    assign bus.busy      = busy_r;
    assign bus.retry_cnt = retry_cnt_r;
    assign bus.retry_hit = retry_hit_r;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_can_tx_scheduler
//
// Directed bench for can_tx_scheduler (NUM_MBOX=4, RETRY_LIMIT=2). Load
// responses and per-mailbox done/fail pulses are predicted into queues by the
// stimulus and consumed by an independent monitor on the falling edge; frame
// and status outputs are checked directly one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_can_tx_scheduler;
    localparam int NUM_MBOX = 4;
    localparam int DATA_W   = 64;
    localparam int ID_W     = 11;

    typedef struct {
        bit                  is_fail;
        logic [NUM_MBOX-1:0] mask;
    } evt_t;

    logic clock;
    logic reset;

    can_tx_scheduler_if #(.NUM_MBOX(NUM_MBOX), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    can_tx_scheduler #(
        .NUM_MBOX(NUM_MBOX), .DATA_W(DATA_W), .ID_W(ID_W), .RETRY_LIMIT(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int   vec_cnt = 0;
    int   err_cnt = 0;
    bit   wr_q[$];
    evt_t evt_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int sel, input logic [ID_W-1:0] id,
                        input logic [DATA_W-1:0] d, input bit exp_ack);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 2'(sel);
        bus.wr_id   = id;
        bus.wr_data = d;
        wr_q.push_back(exp_ack);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic expect_evt(input bit is_fail, input logic [NUM_MBOX-1:0] mask);
        evt_t e;
        e.is_fail = is_fail;
        e.mask    = mask;
        evt_q.push_back(e);
    endtask

    // Monitor: consumes predicted load responses and done/fail pulses.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.wr_ack || bus.wr_err) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr_resp", {62'd0, bus.wr_ack, bus.wr_err}, 64'd0);
                end else begin
                    bit a;
                    a = wr_q.pop_front();
                    chk("wr_resp{ack,err}", {62'd0, bus.wr_ack, bus.wr_err},
                        a ? 64'd2 : 64'd1);
                end
            end
            if ((bus.tx_done != '0) || (bus.tx_fail != '0)) begin
                if (evt_q.size() == 0) begin
                    chk("unexpected_done_fail", {56'd0, bus.tx_done, bus.tx_fail}, 64'd0);
                end else begin
                    evt_t e;
                    e = evt_q.pop_front();
                    chk("tx_done", {60'd0, bus.tx_done}, e.is_fail ? 64'd0 : {60'd0, e.mask});
                    chk("tx_fail", {60'd0, bus.tx_fail}, e.is_fail ? {60'd0, e.mask} : 64'd0);
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_sel      = '0;
        bus.wr_id       = '0;
        bus.wr_data     = '0;
        bus.abort       = '0;
        bus.data_in_req = 1'b0;
        bus.Retransmit  = 1'b0;
        bus.tx_ack      = 1'b0;
        #2;
        chk("rst_pending",   {60'd0, bus.pending}, 64'd0);
        chk("rst_in_packet", bus.In_packet, 64'd0);
        chk("rst_tx_id",     {53'd0, bus.Tx_ID}, 64'd0);
        chk("rst_busy",      {63'd0, bus.busy}, 64'd0);
        chk("rst_wr_ack",    {63'd0, bus.wr_ack}, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single frame: load, arm, commit, deliver.
        load(0, 11'h123, 64'hAA, 1'b1);
        chk("t1_pending",      {60'd0, bus.pending}, 64'h1);
        chk("t1_idle_packet",  bus.In_packet, 64'd0);
        tick();
        chk("t1_armed_id",     {53'd0, bus.Tx_ID}, 64'h123);
        chk("t1_armed_packet", bus.In_packet, 64'hAA);
        chk("t1_armed_busy",   {63'd0, bus.busy}, 64'd0);
        bus.data_in_req = 1'b1;
        tick();
        bus.data_in_req = 1'b0;
        chk("t1_flight_busy",  {63'd0, bus.busy}, 64'd1);
        chk("t1_flight_id",    {53'd0, bus.Tx_ID}, 64'h123);
        bus.tx_ack = 1'b1;
        expect_evt(1'b0, 4'b0001);
        tick();
        bus.tx_ack = 1'b0;
        chk("t1_done_pending", {60'd0, bus.pending}, 64'd0);
        chk("t1_done_packet",  bus.In_packet, 64'd0);
        chk("t1_done_busy",    {63'd0, bus.busy}, 64'd0);

        // Preemption: 0x200 arms first, 0x050 replaces it before commit.
        load(1, 11'h200, 64'h1111, 1'b1);
        load(2, 11'h050, 64'h2222, 1'b1);
        chk("t2_first_armed",  {53'd0, bus.Tx_ID}, 64'h200);
        tick();
        chk("t2_preempt_id",   {53'd0, bus.Tx_ID}, 64'h050);
        chk("t2_preempt_pkt",  bus.In_packet, 64'h2222);
        bus.data_in_req = 1'b1;
        tick();
        bus.data_in_req = 1'b0;
        chk("t2_flight_busy",  {63'd0, bus.busy}, 64'd1);
        chk("t2_flight_id",    {53'd0, bus.Tx_ID}, 64'h050);

        // Rejected loads: in-flight mailbox and zero payload.
        load(2, 11'h7FF, 64'h99, 1'b0);
        chk("t3_inflight_pend", {60'd0, bus.pending}, 64'h6);
        chk("t3_inflight_id",   {53'd0, bus.Tx_ID}, 64'h050);
        chk("t3_inflight_pkt",  bus.In_packet, 64'h2222);
        load(3, 11'h010, 64'h0, 1'b0);
        chk("t3_zero_pend",     {60'd0, bus.pending}, 64'h6);

        // Refetch while in flight keeps the same frame.
        bus.data_in_req = 1'b1;
        tick();
        bus.data_in_req = 1'b0;
        chk("t4_refetch_busy",  {63'd0, bus.busy}, 64'd1);
        chk("t4_refetch_id",    {53'd0, bus.Tx_ID}, 64'h050);

`ifndef RETRY_LIMIT_EN
        for (int i = 0; i < 3; i++) begin
            bus.Retransmit = 1'b1;
            tick();
            bus.Retransmit = 1'b0;
            tick();
        end
        chk("t5_retry_cnt",   {56'd0, bus.retry_cnt}, 64'd3);
        chk("t5_retry_id",    {53'd0, bus.Tx_ID}, 64'h050);
        chk("t5_retry_pkt",   bus.In_packet, 64'h2222);
        chk("t5_retry_busy",  {63'd0, bus.busy}, 64'd1);
        bus.tx_ack = 1'b1;
        expect_evt(1'b0, 4'b0100);
        tick();
        bus.tx_ack = 1'b0;
        chk("t5_done_pending", {60'd0, bus.pending}, 64'h2);
`else
        bus.Retransmit = 1'b1;
        tick();
        bus.Retransmit = 1'b0;
        tick();
        bus.Retransmit = 1'b1;
        tick();
        chk("t5_retry_cnt",   {56'd0, bus.retry_cnt}, 64'd2);
        chk("t5_retry_busy",  {63'd0, bus.busy}, 64'd1);
        expect_evt(1'b1, 4'b0100);
        bus.Retransmit = 1'b0;
        tick();
        chk("t5_fail_busy",    {63'd0, bus.busy}, 64'd0);
        chk("t5_fail_pending", {60'd0, bus.pending}, 64'h2);
        chk("t5_fail_packet",  bus.In_packet, 64'd0);
`endif
        tick();
        chk("t5_next_id",     {53'd0, bus.Tx_ID}, 64'h200);
        chk("t5_next_pkt",    bus.In_packet, 64'h1111);

        // Commit mailbox 1; its own abort is ignored while in flight.
        bus.data_in_req = 1'b1;
        tick();
        bus.data_in_req = 1'b0;
        chk("t6_flight_busy", {63'd0, bus.busy}, 64'd1);
        bus.abort = 4'b0010;
        tick();
        bus.abort = 4'b0000;
        chk("t6_abort_ign_pend", {60'd0, bus.pending}, 64'h2);
        chk("t6_abort_ign_busy", {63'd0, bus.busy}, 64'd1);

        load(0, 11'h010, 64'h33, 1'b1);
        load(3, 11'h300, 64'h44, 1'b1);
        chk("t7_pending",     {60'd0, bus.pending}, 64'hB);
        chk("t7_hold_id",     {53'd0, bus.Tx_ID}, 64'h200);

        // Abort and reload of the same pending, idle mailbox in one cycle.
        bus.abort = 4'b1000;
        expect_evt(1'b1, 4'b1000);
        load(3, 11'h301, 64'h55, 1'b1);
        bus.abort = 4'b0000;
        chk("t8_reload_pend", {60'd0, bus.pending}, 64'hB);
        tick();
        chk("t8_still_busy",  {63'd0, bus.busy}, 64'd1);

        // Asynchronous reset with a frame in flight and three mailboxes pending.
        reset = 1'b1;
        #2;
        chk("t9_rst_pending", {60'd0, bus.pending}, 64'd0);
        chk("t9_rst_busy",    {63'd0, bus.busy}, 64'd0);
        chk("t9_rst_packet",  bus.In_packet, 64'd0);
        chk("t9_rst_id",      {53'd0, bus.Tx_ID}, 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("t9_post_pending", {60'd0, bus.pending}, 64'd0);
        chk("t9_post_busy",    {63'd0, bus.busy}, 64'd0);

        tick();
        chk("wr_q_drained",  64'(wr_q.size()), 64'd0);
        chk("evt_q_drained", 64'(evt_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
